// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 scan-code sequence decoder feeding a 4-entry key event FIFO
module ps2_key_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       scanDone,
  input  logic [7:0] scanCode,
  input  logic       keyRead,
  output logic       keyValid,
  output logic [7:0] keyCode,
  output logic       keyBreak,
  output logic       keyExt,
  output logic [2:0] keyCount,
  output logic       overflow,
  output logic       codeErr
);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;
  state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic scan_done_q;
  logic strobe, bad, push, err_set, pop, full, do_push;
  logic [9:0] push_data;
  logic [9:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] cnt_q;
  logic ovf_q, err_q;
  assign strobe = scanDone & ~scan_done_q;
  assign bad = (scanCode == 8'h00) || (scanCode == 8'hFF);
  assign pop = keyRead & keyValid;
  assign full = cnt_q == 3'd4;
  assign do_push = push & (~full | pop);
  assign keyValid = cnt_q != 3'd0;
  assign keyCount = cnt_q;
  assign keyCode = keyValid ? mem_q[rp_q][7:0] : 8'h00;
  assign keyBreak = keyValid & mem_q[rp_q][8];
  assign keyExt = keyValid & mem_q[rp_q][9];
  assign overflow = ovf_q;
  assign codeErr = err_q;
  // Decode one byte per strobe; prefixes advance state, final byte produces an event
  always_comb begin
    state_d = state_q;
    skip_d = skip_q;
    push = 1'b0;
    err_set = 1'b0;
    push_data = {2'b00, scanCode};
    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (scanCode == 8'hE0) state_d = EXT;
          else if (scanCode == 8'hF0) state_d = BRK;
          else if (scanCode == 8'hE1) begin
            state_d = PAUSE;
            skip_d = 3'd7;
          end
          else if (bad) err_set = 1'b1;
          else push = 1'b1;
        end
        EXT: begin
          if (scanCode == 8'hF0) state_d = EXTBRK;
          else if (scanCode == 8'hE0) state_d = EXT;
          else begin
            state_d = IDLE;
            err_set = bad;
            push = ~bad;
            push_data = {2'b10, scanCode};
          end
        end
        BRK, EXTBRK: begin
          state_d = IDLE;
          err_set = bad;
          push = ~bad;
          push_data = {state_q == EXTBRK, 1'b1, scanCode};
        end
        PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            state_d = IDLE;
            skip_d = 3'd0;
            push = 1'b1;
            push_data = {2'b00, 8'hE1};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Decoder state, edge detector, FIFO pointers/count and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      skip_q <= 3'd0;
      scan_done_q <= 1'b0;
      wp_q <= 2'd0;
      rp_q <= 2'd0;
      cnt_q <= 3'd0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q <= skip_d;
      scan_done_q <= scanDone;
      wp_q <= wp_q + {1'b0, do_push};
      rp_q <= rp_q + {1'b0, pop};
      cnt_q <= cnt_q + {2'b00, do_push} - {2'b00, pop};
      ovf_q <= ovf_q | (push & full & ~pop);
      err_q <= err_q | err_set;
    end
  end
  // FIFO storage; contents are only visible through the count, so no reset needed
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wp_q] <= push_data;
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized byte streams checked against a prefix-list reference model
module tb_ps2_key_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scanDone = 1'b0;
  logic [7:0] scanCode = 8'h00;
  logic keyRead = 1'b0;
  logic keyValid, keyBreak, keyExt, overflow, codeErr;
  logic [7:0] keyCode;
  logic [2:0] keyCount;
  int n_chk = 0;
  int n_pass = 0;
  bit rnd_rd = 0;
  logic [7:0] seq [$];
  logic [9:0] mq [$];
  bit m_err = 0;
  bit m_ovf = 0;
  bit m_prev = 0;
  logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF, 8'h1C, 8'h75, 8'h2A};
  ps2_key_decoder dut (
    .clk(clk), .reset(reset), .scanDone(scanDone), .scanCode(scanCode),
    .keyRead(keyRead), .keyValid(keyValid), .keyCode(keyCode), .keyBreak(keyBreak),
    .keyExt(keyExt), .keyCount(keyCount), .overflow(overflow), .codeErr(codeErr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  task automatic decode(input logic [7:0] b, output bit ev, output logic [9:0] e);
    ev = 0;
    e = '0;
    if (seq.size() > 0 && seq[0] == 8'hE1) begin
      seq.push_back(b);
      if (seq.size() == 8) begin
        ev = 1;
        e = {2'b00, 8'hE1};
        seq.delete();
      end
    end else if (seq.size() == 0 && (b == 8'hE0 || b == 8'hF0 || b == 8'hE1)) seq.push_back(b);
    else if (b == 8'h00 || b == 8'hFF) begin
      m_err = 1;
      seq.delete();
    end else if (seq.size() == 1 && seq[0] == 8'hE0 && (b == 8'hE0 || b == 8'hF0)) begin
      if (b == 8'hF0) seq.push_back(b);
    end else begin
      ev = 1;
      e = {seq.size() > 0 && seq[0] == 8'hE0, seq.size() > 0 && seq[seq.size()-1] == 8'hF0, b};
      seq.delete();
    end
  endtask
  task automatic tick(input logic rst, input logic sd, input logic [7:0] code, input logic rd);
    bit ev;
    logic [9:0] e;
    logic [9:0] h;
    reset = rst;
    scanDone = sd;
    scanCode = code;
    keyRead = rd;
    @(posedge clk);
    if (rst) begin
      seq.delete();
      mq.delete();
      m_err = 0;
      m_ovf = 0;
      m_prev = 0;
    end else begin
      ev = 0;
      e = '0;
      if (sd && !m_prev) decode(code, ev, e);
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (ev) begin
        if (mq.size() < 4) mq.push_back(e);
        else m_ovf = 1;
      end
      m_prev = sd;
    end
    #1;
    h = mq.size() > 0 ? mq[0] : 10'h0;
    check("cycle", {16'h0, keyValid, keyCount, keyExt, keyBreak, keyCode, overflow, codeErr},
          {16'h0, mq.size() > 0, 3'(mq.size()), h, m_ovf, m_err});
  endtask
  task automatic send(input logic [7:0] code, input int hi, input int lo);
    for (int i = 0; i < hi; i++) tick(0, 1, code, rnd_rd && $urandom_range(0, 3) == 0);
    for (int i = 0; i < lo; i++) tick(0, 0, code, rnd_rd && $urandom_range(0, 3) == 0);
  endtask
  initial begin
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] keys [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] b;
    tick(1, 0, 8'h00, 0);
    check("reset", {keyValid, keyCount, keyExt, keyBreak, keyCode, overflow, codeErr}, 16'h0);
    tick(0, 1, 8'h1C, 0);
    check("make_1c", {keyValid, keyCount, keyExt, keyBreak, keyCode}, {1'b1, 3'd1, 2'b00, 8'h1C});
    send(8'h1C, 2, 2);
    tick(1, 0, 8'h00, 0);
    send(8'hE0, 3, 2);
    check("no_ev_e0", keyValid, 0);
    send(8'hF0, 3, 2);
    check("no_ev_f0", keyValid, 0);
    send(8'h75, 3, 2);
    check("ext_brk", {keyExt, keyBreak, keyCode, keyCount}, {2'b11, 8'h75, 3'd1});
    tick(1, 0, 8'h00, 0);
    foreach (pause_seq[i]) send(pause_seq[i], 2, 1);
    check("pause", {keyCount, keyCode}, {3'd1, 8'hE1});
    send(8'h1C, 2, 1);
    check("pause_idle", {keyCount, keyCode}, {3'd2, 8'hE1});
    tick(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 2, 2);
    check("ovf_cnt", {keyCount, overflow}, {3'd4, 1'b1});
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", keyCode, 8'h30 + 8'(i));
      tick(0, 0, 8'h00, 1);
    end
    tick(1, 0, 8'h00, 0);
    foreach (keys[i]) send(keys[i], 2, 2);
    tick(0, 1, 8'h2A, 1);
    check("full_pp", {keyCount, overflow}, {3'd4, 1'b0});
    for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 1);
    check("full_pp_last", {keyCount, keyCode}, {3'd1, 8'h2A});
    tick(1, 0, 8'h00, 0);
    send(8'h1C, 500, 2);
    check("hold", keyCount, 1);
    send(8'h00, 2, 2);
    check("err00", {codeErr, keyCount}, {1'b1, 3'd1});
    tick(1, 0, 8'h00, 0);
    send(8'hE1, 2, 1);
    send(8'h14, 2, 1);
    tick(1, 1, 8'h1C, 0);
    tick(0, 1, 8'h1C, 0);
    check("reset_strobe", {keyCount, keyCode, keyExt}, {3'd1, 8'h1C, 1'b0});
    tick(1, 0, 8'h00, 0);
    rnd_rd = 1;
    for (int n = 0; n < 400; n++) begin
      b = $urandom_range(0, 1) ? pool[$urandom_range(0, 7)] : 8'($urandom);
      if ($urandom_range(0, 59) == 0) tick(1, $urandom_range(0, 1), b, 0);
      send(b, $urandom_range(1, 4), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
